rv_byte_packer: RTL and testbench
=================================

// Module: rv_byte_packer
// PURPOSE
//  Downstream stage of the 8-bit ready/valid FIFO: consumes its byte stream and packs
//  LANES consecutive bytes into one wide word on a ready/valid output, first byte in lane 0.
//  Full throughput (one byte per clock) when the output is not stalled; single output register.
// PARAMETERS
//  DATA_WIDTH  8  width of one input byte / lane
//  LANES       4  bytes per output word (>=2); OUT_WIDTH = DATA_WIDTH*LANES
// PORTS
//  clock_port         in   1           single clock, all state on rising edge
//  reset_port         in   1           asynchronous, active-high reset
//  clear              in   1           synchronous discard of partial and held words
//  input_port_data    in   DATA_WIDTH  byte from upstream FIFO
//  input_port_valid   in   1           byte present
//  input_port_ready   out  1           byte accepted when valid&ready
//  output_port_data   out  OUT_WIDTH   packed word, lane k = bits [k*DATA_WIDTH +: DATA_WIDTH]
//  output_port_keep   out  LANES       per-lane valid mask of output word
//  output_port_valid  out  1           word present
//  output_port_ready  in   1           word consumed when valid&ready
//  flush              in   1           (RV_PACKER_FLUSH_EN only) emit partial word
// BEHAVIOUR
//  - Reset: lane_cnt=0, assembly reg=0, output_port_valid=0, output_port_data=0,
//    output_port_keep=0; input_port_ready=1 in the first cycle after reset release.
//  - Accept: byte stored in assembly lane lane_cnt; lane_cnt increments, wraps LANES-1 -> 0.
//  - Completion: byte accepted into lane LANES-1 -> on the same edge the full word (incl. that
//    byte) loads the output register, keep=all ones, valid=1. Latency: valid in the cycle
//    after the last byte is accepted.
//  - Output register is free when !output_port_valid or output_port_ready (drain and reload
//    on the same edge is allowed; no bubble).
//  - input_port_ready = !(lane_cnt==LANES-1 && output_port_valid && !output_port_ready);
//    lanes 0..LANES-2 are always accepted. Ready is combinational from output_port_ready only.
//  - Output data/keep hold stable while valid && !ready; valid drops after handshake unless
//    reloaded on the same edge.
//  - clear (sync, highest priority below reset): lane_cnt=0, assembly=0, output_port_valid=0,
//    keep=0; the byte offered in the clear cycle is dropped (not counted).
//  - Reset asserted mid-word: partial word and held output discarded immediately.
//  - Unused assembly lanes are 0 (never stale data) after each load into the output register.
// CONFIGURATION
//  RV_PACKER_FLUSH_EN defined: flush port exists. flush with lane_cnt>0 (counting a byte
//   accepted in the same cycle) loads the partial word, keep = lanes filled (e.g. 3 bytes ->
//   4'b0111), unused lanes 0, lane_cnt=0. flush with nothing pending: no effect. While the
//   output is stalled, a pending flush blocks input_port_ready and takes effect once the
//   register frees (flush must be held by the caller until then).
//  RV_PACKER_FLUSH_EN undefined: no flush port; keep is all ones whenever valid, else 0.
// STRUCTURE
//  - Shared package rv_pkg: byte typedef (logic [DATA_WIDTH-1:0]) and lane-count width
//    function clog2(LANES); rv_byte_packer imports it.
//  - One sub-module: rv_out_reg (ready/valid holding register, data+keep, load/drain logic).
//  - Packer top: lane counter, assembly register, ready/flush control.
// TESTING
//  1 Reset: hold reset_port mid-stream -> valid=0, keep=0, ready=1 after release.
//  2 Stream 0x11,0x22,0x33,0x44 back-to-back, out ready=1 -> data 0x44332211, keep 4'hF,
//    valid one cycle after 0x44 accepted; 8 bytes in 8 clocks -> 2 words, no bubbles.
//  3 Stall: out ready=0 with word held, send 4 more bytes -> first 3 accepted, 4th byte sees
//    ready=0; raise out ready -> 0x44332211 handshakes and the new word loads on the same edge.
//  4 clear after 2 bytes (0xAA,0xBB), then send 0x01..0x04 -> only 0x04030201 emerges.
//  5 (FLUSH_EN) bytes 0x55,0x66,0x77 then flush -> data 0x00776655, keep 4'b0111;
//    flush with lane_cnt=0 -> no output.
//  6 Random valid/ready for 10k bytes vs scoreboard: byte order, keep, no loss/duplication.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg -- shared definitions for the ready/valid byte-stream blocks.
//   BYTE_WIDTH : width of one stream byte
//   rv_byte_t  : one stream byte
//   lane_cnt_w : width of a counter that indexes LANES lanes (at least 1 bit)
package rv_pkg;

    localparam int BYTE_WIDTH = 8;

    typedef logic [BYTE_WIDTH-1:0] rv_byte_t;

    function automatic int lane_cnt_w(input int lanes);
        return (lanes <= 2) ? 1 : $clog2(lanes);
    endfunction

endpackage

// File: rtl/rv_out_reg.sv
// rv_out_reg -- single ready/valid holding register for a data word plus keep mask.
//   clock_port, reset_port : clock, async active-high reset
//   clear                  : sync discard of the held word (beats load)
//   load, load_data/keep   : capture a new word; the caller only loads when the
//                            register is free (empty or draining this edge)
//   ready                  : downstream ready
//   valid, data, keep      : held word; stable while valid && !ready
module rv_out_reg #(
    parameter int WIDTH = 32,
    parameter int LANES = 4
) (
    input  logic             clock_port,
    input  logic             reset_port,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LANES-1:0] load_keep,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [LANES-1:0] keep
);

    always_ff @(posedge clock_port or posedge reset_port) begin
        if (reset_port) begin
            valid <= 1'b0;
            data  <= '0;
            keep  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            keep  <= '0;
        end else if (load) begin
            // Covers drain-and-reload on the same edge: no bubble.
            valid <= 1'b1;
            data  <= load_data;
            keep  <= load_keep;
        end else if (valid && ready) begin
            // Keep follows valid so an empty register always shows keep == 0.
            valid <= 1'b0;
            keep  <= '0;
        end
    end

endmodule

// File: rtl/rv_byte_packer.sv
// rv_byte_packer -- packs LANES consecutive bytes into one word, first byte in lane 0.
//   clock_port, reset_port       : clock, async active-high reset
//   clear                        : sync discard of partial and held words
//   input_port_data/valid/ready  : byte stream in
//   output_port_data/keep/valid/ready : packed word out (lane k = bits [k*DATA_WIDTH +: DATA_WIDTH])
//   flush                        : emit the partial word (only with RV_PACKER_FLUSH_EN)
// Build option: RV_PACKER_FLUSH_EN adds the flush port and partial-word keep masks.
// One byte per clock when the output is not stalled; only the byte that would
// complete a word is held off while a full word is stuck in the output register.
module rv_byte_packer
    import rv_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    localparam int OUT_WIDTH = DATA_WIDTH * LANES
) (
    input  logic                  clock_port,
    input  logic                  reset_port,
    input  logic                  clear,
`ifdef RV_PACKER_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic [DATA_WIDTH-1:0] input_port_data,
    input  logic                  input_port_valid,
    output logic                  input_port_ready,
    output logic [OUT_WIDTH-1:0]  output_port_data,
    output logic [LANES-1:0]      output_port_keep,
    output logic                  output_port_valid,
    input  logic                  output_port_ready
);

    localparam int            CW   = lane_cnt_w(LANES);
    localparam logic [CW-1:0] LAST = CW'(LANES - 1);

    logic [CW-1:0]                       lane_cnt;
    logic [LANES-1:0][DATA_WIDTH-1:0]    asm_q;
    logic [LANES-1:0][DATA_WIDTH-1:0]    asm_next;
    logic [LANES-1:0]                    load_keep;
    logic                                out_free;
    logic                                is_last;
    logic                                accept;
    logic                                load;

    assign out_free = !output_port_valid || output_port_ready;
    assign is_last  = (lane_cnt == LAST);

`ifdef RV_PACKER_FLUSH_EN
    logic flush_pend;
    logic flush_fire;
    int   fill;

    // A flush with bytes pending waits for the output register; until then
    // stop taking bytes so the partial word does not grow under it.
    assign flush_pend       = flush && (lane_cnt != '0);
    assign input_port_ready = out_free || !(is_last || flush_pend);
    assign accept           = input_port_valid && input_port_ready && !clear;
    // The byte accepted this cycle counts toward the flushed word.
    assign flush_fire       = flush && !clear && out_free && ((lane_cnt != '0) || accept);
    assign load             = (accept && is_last) || flush_fire;

    always_comb begin
        fill      = int'(lane_cnt) + int'(accept);
        load_keep = '0;
        for (int k = 0; k < LANES; k++)
            load_keep[k] = (k < fill);
    end
`else
    assign input_port_ready = out_free || !is_last;
    assign accept           = input_port_valid && input_port_ready && !clear;
    assign load             = accept && is_last;
    assign load_keep        = '1;
`endif

    // Word as it will look with this cycle's byte placed; this is what loads.
    always_comb begin
        asm_next = asm_q;
        if (accept)
            asm_next[lane_cnt] = input_port_data;
    end

    always_ff @(posedge clock_port or posedge reset_port) begin
        if (reset_port) begin
            lane_cnt <= '0;
            asm_q    <= '0;
        end else if (clear || load) begin
            // Zeroing on load keeps unused lanes of a later partial word clean.
            lane_cnt <= '0;
            asm_q    <= '0;
        end else if (accept) begin
            lane_cnt <= lane_cnt + CW'(1);
            asm_q    <= asm_next;
        end
    end

    rv_out_reg #(
        .WIDTH (OUT_WIDTH),
        .LANES (LANES)
    ) u_out_reg (
        .clock_port (clock_port),
        .reset_port (reset_port),
        .clear      (clear),
        .load       (load),
        .load_data  (asm_next),
        .load_keep  (load_keep),
        .ready      (output_port_ready),
        .valid      (output_port_valid),
        .data       (output_port_data),
        .keep       (output_port_keep)
    );

endmodule

// File: tb/tb_rv_byte_packer.sv
// tb_rv_byte_packer -- self-checking bench for rv_byte_packer (DATA_WIDTH=8, LANES=4).
// Directed per-cycle vector table, hand-written reset/flush sequences, then a
// randomized valid/ready run checked against a byte-queue scoreboard.
module tb_rv_byte_packer;
    import rv_pkg::*;

    localparam int DW = 8;
    localparam int LN = 4;
    localparam int OW = DW * LN;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    rv_byte_t      id = '0;
    logic          iv = 1'b0;
    logic          irdy;
    logic [OW-1:0] od;
    logic [LN-1:0] okeep;
    logic          ov;
    logic          ordy = 1'b0;
`ifdef RV_PACKER_FLUSH_EN
    logic          flush = 1'b0;
`endif

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    rv_byte_packer #(.DATA_WIDTH(DW), .LANES(LN)) dut (
        .clock_port        (clk),
        .reset_port        (rst),
        .clear             (clear),
`ifdef RV_PACKER_FLUSH_EN
        .flush             (flush),
`endif
        .input_port_data   (id),
        .input_port_valid  (iv),
        .input_port_ready  (irdy),
        .output_port_data  (od),
        .output_port_keep  (okeep),
        .output_port_valid (ov),
        .output_port_ready (ordy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One cycle: inputs, expected ready before the edge, expected output after it.
    typedef struct {
        logic [7:0]  d;
        logic        v, r, c;
        logic        e_rdy, e_ov;
        logic [31:0] e_data;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] d, input logic v, input logic r,
                                input logic c, input logic e_rdy, input logic e_ov,
                                input logic [31:0] e_data);
        vec_t x;
        x.d = d; x.v = v; x.r = r; x.c = c;
        x.e_rdy = e_rdy; x.e_ov = e_ov; x.e_data = e_data;
        return x;
    endfunction

    task automatic step(input vec_t x, input string tag);
        id = x.d; iv = x.v; ordy = x.r; clear = x.c;
        #1;
        chk({tag, " ready"}, irdy, x.e_rdy);
        @(posedge clk); #1;
        chk({tag, " valid"}, ov, x.e_ov);
        chk({tag, " keep"}, okeep, x.e_ov ? 4'hF : 4'h0);
        if (x.e_ov) chk({tag, " data"}, od, x.e_data);
    endtask

    vec_t     tbl[$];
    rv_byte_t pend[$];
    logic [31:0] expq[$];

    initial begin
        // Stream of 8 bytes, no stall: words on cycles 3 and 7, ready always high.
        tbl.push_back(mk(8'h11,1,1,0, 1,0,0));
        tbl.push_back(mk(8'h22,1,1,0, 1,0,0));
        tbl.push_back(mk(8'h33,1,1,0, 1,0,0));
        tbl.push_back(mk(8'h44,1,1,0, 1,1,32'h44332211));
        tbl.push_back(mk(8'h55,1,1,0, 1,0,0));
        tbl.push_back(mk(8'h66,1,1,0, 1,0,0));
        tbl.push_back(mk(8'h77,1,1,0, 1,0,0));
        tbl.push_back(mk(8'h88,1,1,0, 1,1,32'h88776655));
        // Stall: lanes 0..2 accepted, lane 3 refused, then drain+reload same edge.
        tbl.push_back(mk(8'h01,1,0,0, 1,1,32'h88776655));
        tbl.push_back(mk(8'h02,1,0,0, 1,1,32'h88776655));
        tbl.push_back(mk(8'h03,1,0,0, 1,1,32'h88776655));
        tbl.push_back(mk(8'h04,1,0,0, 0,1,32'h88776655));
        tbl.push_back(mk(8'h04,1,1,0, 1,1,32'h04030201));
        tbl.push_back(mk(8'h00,0,1,0, 1,0,0));
        // clear after two bytes; the byte offered during clear is dropped.
        tbl.push_back(mk(8'hAA,1,1,0, 1,0,0));
        tbl.push_back(mk(8'hBB,1,1,0, 1,0,0));
        tbl.push_back(mk(8'hCC,1,1,1, 1,0,0));
        tbl.push_back(mk(8'h01,1,1,0, 1,0,0));
        tbl.push_back(mk(8'h02,1,1,0, 1,0,0));
        tbl.push_back(mk(8'h03,1,1,0, 1,0,0));
        tbl.push_back(mk(8'h04,1,1,0, 1,1,32'h04030201));
        tbl.push_back(mk(8'h00,0,1,0, 1,0,0));
        // clear discards a held word.
        tbl.push_back(mk(8'h10,1,0,0, 1,0,0));
        tbl.push_back(mk(8'h20,1,0,0, 1,0,0));
        tbl.push_back(mk(8'h30,1,0,0, 1,0,0));
        tbl.push_back(mk(8'h40,1,0,0, 1,1,32'h40302010));
        tbl.push_back(mk(8'h00,0,0,1, 1,0,0));

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset valid", ov, 1'b0);
        chk("reset keep", okeep, 4'h0);
        chk("reset data", od, 32'h0);
        rst = 1'b0;
        #1;
        chk("reset ready", irdy, 1'b1);

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], $sformatf("vec%0d", i));

        // Reset mid-stream with a held word and a 2-byte partial.
        step(mk(8'hB0,1,0,0, 1,0,0), "mr0");
        step(mk(8'hB1,1,0,0, 1,0,0), "mr1");
        step(mk(8'hB2,1,0,0, 1,0,0), "mr2");
        step(mk(8'hB3,1,0,0, 1,1,32'hB3B2B1B0), "mr3");
        step(mk(8'hC0,1,0,0, 1,1,32'hB3B2B1B0), "mr4");
        step(mk(8'hC1,1,0,0, 1,1,32'hB3B2B1B0), "mr5");
        iv = 1'b0;
        rst = 1'b1;
        #2;
        chk("midrst valid", ov, 1'b0);
        chk("midrst keep", okeep, 4'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst ready", irdy, 1'b1);
        step(mk(8'hA1,1,1,0, 1,0,0), "pr0");
        step(mk(8'hA2,1,1,0, 1,0,0), "pr1");
        step(mk(8'hA3,1,1,0, 1,0,0), "pr2");
        step(mk(8'hA4,1,1,0, 1,1,32'hA4A3A2A1), "pr3");
        step(mk(8'h00,0,1,0, 1,0,0), "pr4");

`ifdef RV_PACKER_FLUSH_EN
        step(mk(8'h55,1,1,0, 1,0,0), "fl0");
        step(mk(8'h66,1,1,0, 1,0,0), "fl1");
        step(mk(8'h77,1,1,0, 1,0,0), "fl2");
        iv = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        chk("flush valid", ov, 1'b1);
        chk("flush keep", okeep, 4'b0111);
        chk("flush data", od, 32'h00776655);
        @(posedge clk); #1;
        chk("flush empty valid", ov, 1'b0);
        @(posedge clk); #1;
        chk("flush empty valid2", ov, 1'b0);
        flush = 1'b0;
        // Flush while stalled blocks ready; fires with the same-cycle byte once free.
        step(mk(8'h0A,1,0,0, 1,0,0), "fs0");
        step(mk(8'h0B,1,0,0, 1,0,0), "fs1");
        step(mk(8'h0C,1,0,0, 1,0,0), "fs2");
        step(mk(8'h0D,1,0,0, 1,1,32'h0D0C0B0A), "fs3");
        step(mk(8'h01,1,0,0, 1,1,32'h0D0C0B0A), "fs4");
        step(mk(8'h02,1,0,0, 1,1,32'h0D0C0B0A), "fs5");
        id = 8'h03; iv = 1'b1; flush = 1'b1;
        #1;
        chk("flush stall ready", irdy, 1'b0);
        @(posedge clk); #1;
        chk("flush stall hold", od, 32'h0D0C0B0A);
        ordy = 1'b1;
        #1;
        chk("flush free ready", irdy, 1'b1);
        @(posedge clk); #1;
        chk("flush free valid", ov, 1'b1);
        chk("flush free keep", okeep, 4'b0111);
        chk("flush free data", od, 32'h00030201);
        flush = 1'b0;
        step(mk(8'h00,0,1,0, 1,0,0), "fs6");
`endif

        // Randomized run against a byte-queue scoreboard.
        begin
            int          acc = 0;
            int          cyc = 0;
            logic        pov = 1'b0;
            logic        pordy = 1'b1;
            logic [31:0] pdata = '0;
            logic [31:0] w;
            clear = 1'b1; iv = 1'b0;
            @(posedge clk); #1;
            clear = 1'b0;
            while (acc < 10000 && cyc < 60000) begin
                iv   = ($urandom_range(0, 9) < 7);
                id   = rv_byte_t'($urandom);
                ordy = ($urandom_range(0, 9) < 6);
                #1;
                if (pov && !pordy) begin
                    chk("rnd hold valid", ov, 1'b1);
                    chk("rnd hold data", od, pdata);
                end
                chk("rnd ready", irdy, !(pend.size() == LN-1 && ov && !ordy));
                if (ov && ordy) begin
                    if (expq.size() == 0) begin
                        tot_cnt++;
                        $display("FAIL rnd spurious word: got %0h, expected none", od);
                    end else begin
                        w = expq.pop_front();
                        chk("rnd data", od, w);
                        chk("rnd keep", okeep, 4'hF);
                    end
                end
                if (iv && irdy) begin
                    pend.push_back(id);
                    acc++;
                    if (pend.size() == LN) begin
                        w = '0;
                        for (int k = 0; k < LN; k++) w[k*DW +: DW] = pend[k];
                        pend.delete();
                        expq.push_back(w);
                    end
                end
                pov = ov; pordy = ordy; pdata = od;
                @(posedge clk); #1;
                cyc++;
            end
            if (acc < 10000) begin
                tot_cnt++;
                $display("FAIL rnd timeout: got %0d bytes, expected 10000", acc);
            end
            iv = 1'b0; ordy = 1'b1;
            for (int i = 0; i < 20; i++) begin
                #1;
                if (ov) begin
                    if (expq.size() == 0) begin
                        tot_cnt++;
                        $display("FAIL rnd drain spurious: got %0h, expected none", od);
                    end else begin
                        w = expq.pop_front();
                        chk("rnd drain data", od, w);
                    end
                end
                @(posedge clk); #1;
            end
            chk("rnd words left", expq.size(), 0);
            chk("rnd bytes left", pend.size(), 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
